// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite geometry, ball sequencer types and constants
package sprite_pkg;

    localparam int SCREEN_H_RES     = 640;
    localparam int SCREEN_V_RES     = 480;
    localparam int BALL_SIDE        = 10;
    localparam int PADDLE_HEIGHT    = 50;
    localparam int SCREEN_BORDER    = 10;
    localparam int SPEED_W          = 5;
    localparam int MAX_SPEED_X      = 8;
    localparam int SERVE_FRAMES     = 60;

    localparam int X_POS_W          = 10;
    localparam int Y_POS_W          = 9;

    localparam int HIT_ZONE         = PADDLE_HEIGHT / 3;
    localparam int HIT_ZONE_HI      = 2 * PADDLE_HEIGHT / 3;

    localparam int INIT_SPEED_B     = 4;
    localparam int DEFLECT_SPEED_Y  = 1;
    localparam int SIDE_HIT_SPEED_Y = 5;

    localparam int SERVE_CNT_W      = $clog2(SERVE_FRAMES);

    typedef struct packed {
        logic [X_POS_W-1:0] x_pos;
        logic [Y_POS_W-1:0] y_pos;
        logic [X_POS_W-1:0] right;
        logic [Y_POS_W-1:0] bottom;
    } sprite_t;

    // One guard bit so position sums never wrap before clamping.
    typedef logic [X_POS_W:0] x_ext_t;
    typedef logic [Y_POS_W:0] y_ext_t;

    // Signed paddle offset: guard bit plus sign bit.
    typedef logic signed [Y_POS_W+1:0] y_off_t;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        MOVE  = 2'd1,
        CHECK = 2'd2,
        SCORE = 2'd3
    } ball_state_e;

    typedef enum logic [1:0] {
        ZONE_TOP = 2'd0,
        ZONE_MID = 2'd1,
        ZONE_BOT = 2'd2
    } hit_zone_e;

    localparam sprite_t INIT_ST_B = '{
        x_pos:  X_POS_W'((SCREEN_H_RES - BALL_SIDE) / 2),
        y_pos:  Y_POS_W'((SCREEN_V_RES - BALL_SIDE) / 2),
        right:  X_POS_W'((SCREEN_H_RES + BALL_SIDE) / 2),
        bottom: Y_POS_W'((SCREEN_V_RES + BALL_SIDE) / 2)
    };

    // Build a ball sprite from an already-clamped top-left corner.
    function automatic sprite_t place_ball(input x_ext_t x, input y_ext_t y);
        sprite_t s;
        s.x_pos  = X_POS_W'(x);
        s.y_pos  = Y_POS_W'(y);
        s.right  = X_POS_W'(x + x_ext_t'(BALL_SIDE));
        s.bottom = Y_POS_W'(y + y_ext_t'(BALL_SIDE));
        return s;
    endfunction

endpackage

// File: rtl/paddle_hit.sv
// rtl/paddle_hit.sv - combinational ball/paddle overlap test and hit zone
module paddle_hit
    import sprite_pkg::*;
(
    input  sprite_t   i_ball,
    input  sprite_t   i_pad,
    output logic      o_hit,
    output hit_zone_e o_zone
);

    y_off_t w_offset;

    assign o_hit = (i_ball.right  > i_pad.x_pos) &&
                   (i_ball.x_pos  < i_pad.right) &&
                   (i_ball.bottom > i_pad.y_pos) &&
                   (i_ball.y_pos  < i_pad.bottom);

    // Ball centre relative to paddle top; negative when the ball clips the top edge.
    assign w_offset = y_off_t'({2'b00, i_ball.y_pos}) + y_off_t'(BALL_SIDE / 2)
                    - y_off_t'({2'b00, i_pad.y_pos});

    // Classify the contact point into top / middle / bottom thirds.
    always_comb begin
        o_zone = ZONE_MID;
        if (w_offset < y_off_t'(HIT_ZONE)) begin
            o_zone = ZONE_TOP;
        end else if (w_offset >= y_off_t'(HIT_ZONE_HI)) begin
            o_zone = ZONE_BOT;
        end
    end

endmodule

// File: rtl/ball_ctrl.sv
// rtl/ball_ctrl.sv - per-frame ball sequencer: serve, move, collide, score
module ball_ctrl
    import sprite_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               frame_tick_i,
    input  sprite_t            player_i,
    input  sprite_t            enemy_i,
    output sprite_t            ball_o,
    output logic [SPEED_W-1:0] speed_x_o,
    output logic [SPEED_W-1:0] speed_y_o,
    output logic               dir_x_o,
    output logic               dir_y_o,
    output logic               serving_o,
    output logic               score_player_o,
    output logic               score_enemy_o
);

    ball_state_e            r_state;
    logic [SERVE_CNT_W-1:0] r_cnt;
    sprite_t                r_ball;
    logic [SPEED_W-1:0]     r_speed_x;
    logic [SPEED_W-1:0]     r_speed_y;
    logic                   r_dir_x;
    logic                   r_dir_y;
    logic                   r_serving;
    logic                   r_score_p;
    logic                   r_score_e;

    ball_state_e            w_state_nxt;
    logic [SERVE_CNT_W-1:0] w_cnt_nxt;
    sprite_t                w_ball_nxt;
    logic [SPEED_W-1:0]     w_speed_x_nxt;
    logic [SPEED_W-1:0]     w_speed_y_nxt;
    logic                   w_dir_x_nxt;
    logic                   w_dir_y_nxt;
    logic                   w_serving_nxt;
    logic                   w_score_p_nxt;
    logic                   w_score_e_nxt;

    x_ext_t                 w_x_ext;
    y_ext_t                 w_y_ext;
    x_ext_t                 w_x_fwd;
    x_ext_t                 w_mv_x;
    y_ext_t                 w_mv_y;
    logic                   w_miss_r;
    logic                   w_miss_l;

    logic                   w_hit_player;
    logic                   w_hit_enemy;
    hit_zone_e              w_zone_player;
    hit_zone_e              w_zone_enemy;
    logic                   w_sel_hit;
    hit_zone_e              w_sel_zone;

    x_ext_t                 w_chk_x;
    y_ext_t                 w_chk_y;
    logic                   w_chk_dir_x;
    logic                   w_chk_dir_y;
    logic [SPEED_W-1:0]     w_chk_speed_x;
    logic [SPEED_W-1:0]     w_chk_speed_y;

    paddle_hit u_hit_player (
        .i_ball (r_ball),
        .i_pad  (player_i),
        .o_hit  (w_hit_player),
        .o_zone (w_zone_player)
    );

    paddle_hit u_hit_enemy (
        .i_ball (r_ball),
        .i_pad  (enemy_i),
        .o_hit  (w_hit_enemy),
        .o_zone (w_zone_enemy)
    );

    // Only the paddle the ball is travelling toward can deflect it.
    assign w_sel_hit  = r_dir_x ? w_hit_player  : w_hit_enemy;
    assign w_sel_zone = r_dir_x ? w_zone_player : w_zone_enemy;

    // Widened move arithmetic; the left-miss test compares before subtracting.
    assign w_x_ext  = x_ext_t'(r_ball.x_pos);
    assign w_y_ext  = y_ext_t'(r_ball.y_pos);
    assign w_x_fwd  = w_x_ext + x_ext_t'(r_speed_x);
    assign w_miss_r = r_dir_x && ((w_x_fwd + x_ext_t'(BALL_SIDE)) > x_ext_t'(SCREEN_H_RES));
    assign w_miss_l = !r_dir_x && (w_x_ext < x_ext_t'(r_speed_x));
    assign w_mv_x   = r_dir_x ? w_x_fwd : (w_x_ext - x_ext_t'(r_speed_x));
    assign w_mv_y   = r_dir_y ? (w_y_ext + y_ext_t'(r_speed_y))
                              : (w_y_ext - y_ext_t'(r_speed_y));

    // Collision resolution on the moved ball: paddle first, then walls on the result.
    always_comb begin
        w_chk_x       = w_x_ext;
        w_chk_y       = w_y_ext;
        w_chk_dir_x   = r_dir_x;
        w_chk_dir_y   = r_dir_y;
        w_chk_speed_x = r_speed_x;
        w_chk_speed_y = r_speed_y;

        if (w_sel_hit) begin
            w_chk_dir_x   = ~r_dir_x;
            w_chk_x       = r_dir_x ? (x_ext_t'(player_i.x_pos) - x_ext_t'(BALL_SIDE))
                                    : x_ext_t'(enemy_i.right);
            w_chk_speed_x = (r_speed_x >= SPEED_W'(MAX_SPEED_X)) ? SPEED_W'(MAX_SPEED_X)
                                                                 : (r_speed_x + SPEED_W'(1));
            case (w_sel_zone)
                ZONE_TOP: begin
                    w_chk_speed_y = SPEED_W'(SIDE_HIT_SPEED_Y);
                    w_chk_dir_y   = 1'b0;
                end
                ZONE_BOT: begin
                    w_chk_speed_y = SPEED_W'(SIDE_HIT_SPEED_Y);
                    w_chk_dir_y   = 1'b1;
                end
                default: begin
                    w_chk_speed_y = SPEED_W'(DEFLECT_SPEED_Y);
                end
            endcase
        end

        if (!w_chk_dir_y && (w_chk_y <= y_ext_t'(SCREEN_BORDER))) begin
            w_chk_y     = y_ext_t'(SCREEN_BORDER);
            w_chk_dir_y = 1'b1;
        end else if (w_chk_dir_y &&
                     ((w_chk_y + y_ext_t'(BALL_SIDE)) >= y_ext_t'(SCREEN_V_RES - SCREEN_BORDER))) begin
            w_chk_y     = y_ext_t'(SCREEN_V_RES - SCREEN_BORDER - BALL_SIDE);
            w_chk_dir_y = 1'b0;
        end
    end

    // Next-state and next-register selection for the serve/move/check/score sequence.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ball_nxt    = r_ball;
        w_speed_x_nxt = r_speed_x;
        w_speed_y_nxt = r_speed_y;
        w_dir_x_nxt   = r_dir_x;
        w_dir_y_nxt   = r_dir_y;
        w_serving_nxt = r_serving;
        w_score_p_nxt = 1'b0;
        w_score_e_nxt = 1'b0;

        case (r_state)
            SERVE: begin
                if (frame_tick_i) begin
                    if (r_cnt == SERVE_CNT_W'(SERVE_FRAMES - 1)) begin
                        w_cnt_nxt     = '0;
                        w_serving_nxt = 1'b0;
                        w_state_nxt   = MOVE;
                    end else begin
                        w_cnt_nxt = r_cnt + SERVE_CNT_W'(1);
                    end
                end
            end
            MOVE: begin
                if (frame_tick_i) begin
                    if (w_miss_r) begin
                        w_score_e_nxt = 1'b1;
                        w_state_nxt   = SCORE;
                    end else if (w_miss_l) begin
                        w_score_p_nxt = 1'b1;
                        w_state_nxt   = SCORE;
                    end else begin
                        w_ball_nxt  = place_ball(w_mv_x, w_mv_y);
                        w_state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                w_ball_nxt    = place_ball(w_chk_x, w_chk_y);
                w_dir_x_nxt   = w_chk_dir_x;
                w_dir_y_nxt   = w_chk_dir_y;
                w_speed_x_nxt = w_chk_speed_x;
                w_speed_y_nxt = w_chk_speed_y;
                w_state_nxt   = MOVE;
            end
            SCORE: begin
                w_ball_nxt    = INIT_ST_B;
                w_speed_x_nxt = SPEED_W'(INIT_SPEED_B);
                w_speed_y_nxt = SPEED_W'(DEFLECT_SPEED_Y);
                w_dir_x_nxt   = r_score_e;
                w_serving_nxt = 1'b1;
                w_cnt_nxt     = '0;
                w_state_nxt   = SERVE;
            end
            default: begin
                w_state_nxt = SERVE;
            end
        endcase
    end

    // State and datapath registers, all asynchronously reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= SERVE;
            r_cnt     <= '0;
            r_ball    <= INIT_ST_B;
            r_speed_x <= SPEED_W'(INIT_SPEED_B);
            r_speed_y <= SPEED_W'(DEFLECT_SPEED_Y);
            r_dir_x   <= 1'b0;
            r_dir_y   <= 1'b1;
            r_serving <= 1'b1;
            r_score_p <= 1'b0;
            r_score_e <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ball    <= w_ball_nxt;
            r_speed_x <= w_speed_x_nxt;
            r_speed_y <= w_speed_y_nxt;
            r_dir_x   <= w_dir_x_nxt;
            r_dir_y   <= w_dir_y_nxt;
            r_serving <= w_serving_nxt;
            r_score_p <= w_score_p_nxt;
            r_score_e <= w_score_e_nxt;
        end
    end

    assign ball_o         = r_ball;
    assign speed_x_o      = r_speed_x;
    assign speed_y_o      = r_speed_y;
    assign dir_x_o        = r_dir_x;
    assign dir_y_o        = r_dir_y;
    assign serving_o      = r_serving;
    assign score_player_o = r_score_p;
    assign score_enemy_o  = r_score_e;

endmodule

// File: tb/tb_ball_ctrl.sv
// tb/tb_ball_ctrl.sv - randomized scoreboard bench for ball_ctrl
module tb_ball_ctrl;
    import sprite_pkg::*;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               frame_tick_i;
    sprite_t            player_i;
    sprite_t            enemy_i;
    sprite_t            ball_o;
    logic [SPEED_W-1:0] speed_x_o;
    logic [SPEED_W-1:0] speed_y_o;
    logic               dir_x_o;
    logic               dir_y_o;
    logic               serving_o;
    logic               score_player_o;
    logic               score_enemy_o;

    always #5 clk_i = ~clk_i;

    ball_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .frame_tick_i   (frame_tick_i),
        .player_i       (player_i),
        .enemy_i        (enemy_i),
        .ball_o         (ball_o),
        .speed_x_o      (speed_x_o),
        .speed_y_o      (speed_y_o),
        .dir_x_o        (dir_x_o),
        .dir_y_o        (dir_y_o),
        .serving_o      (serving_o),
        .score_player_o (score_player_o),
        .score_enemy_o  (score_enemy_o)
    );

    typedef struct {
        int x, y, sx, sy, dx, dy, serving, se, sp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   did_reset = 0;

    // Reference game state: plain integers following the game rules.
    int m_x, m_y, m_sx, m_sy, m_dx, m_dy, m_serving, m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 315; m_y = 235; m_sx = 4; m_sy = 1;
        m_dx = 0;  m_dy = 1;  m_serving = 1; m_cnt = 0;
    endtask

    task automatic model_reload();
        m_x = 315; m_y = 235; m_sx = 4; m_sy = 1;
        m_serving = 1; m_cnt = 0;
    endtask

    task automatic model_tick(output exp_t e);
        int px, pr, py, pb, off;
        e.se = 0;
        e.sp = 0;
        if (m_serving != 0) begin
            if (m_cnt == SERVE_FRAMES - 1) begin
                m_cnt = 0;
                m_serving = 0;
            end else begin
                m_cnt++;
            end
        end else if (m_dx == 1 && m_x + m_sx + BALL_SIDE > SCREEN_H_RES) begin
            e.se = 1;
            model_reload();
            m_dx = 1;
        end else if (m_dx == 0 && m_x < m_sx) begin
            e.sp = 1;
            model_reload();
            m_dx = 0;
        end else begin
            m_x = (m_dx == 1) ? m_x + m_sx : m_x - m_sx;
            m_y = (m_dy == 1) ? m_y + m_sy : m_y - m_sy;
            if (m_dx == 1) begin
                px = player_i.x_pos; pr = player_i.right; py = player_i.y_pos; pb = player_i.bottom;
            end else begin
                px = enemy_i.x_pos;  pr = enemy_i.right;  py = enemy_i.y_pos;  pb = enemy_i.bottom;
            end
            if (m_x + BALL_SIDE > px && m_x < pr && m_y + BALL_SIDE > py && m_y < pb) begin
                m_x  = (m_dx == 1) ? px - BALL_SIDE : pr;
                m_dx = 1 - m_dx;
                m_sx = (m_sx + 1 > MAX_SPEED_X) ? MAX_SPEED_X : m_sx + 1;
                off  = m_y + BALL_SIDE / 2 - py;
                if (off < PADDLE_HEIGHT / 3) begin
                    m_sy = 5; m_dy = 0;
                end else if (off >= 2 * PADDLE_HEIGHT / 3) begin
                    m_sy = 5; m_dy = 1;
                end else begin
                    m_sy = 1;
                end
            end
            if (m_dy == 0 && m_y <= SCREEN_BORDER) begin
                m_y = SCREEN_BORDER; m_dy = 1;
            end else if (m_dy == 1 && m_y + BALL_SIDE >= SCREEN_V_RES - SCREEN_BORDER) begin
                m_y = SCREEN_V_RES - SCREEN_BORDER - BALL_SIDE; m_dy = 0;
            end
        end
        e.x = m_x; e.y = m_y; e.sx = m_sx; e.sy = m_sy;
        e.dx = m_dx; e.dy = m_dy; e.serving = m_serving;
    endtask

    function automatic int pick_pad_y();
        int r, py;
        r = $urandom_range(0, 50);
        if ($urandom_range(0, 3) != 0) py = m_y + 5 - r;
        else                           py = $urandom_range(0, 430);
        if (py < 0)   py = 0;
        if (py > 430) py = 430;
        return py;
    endfunction

    task automatic rand_paddles();
        int py;
        py = pick_pad_y();
        player_i.x_pos = 10'd610; player_i.right = 10'd620;
        player_i.y_pos = 9'(py);  player_i.bottom = 9'(py + PADDLE_HEIGHT);
        py = pick_pad_y();
        enemy_i.x_pos = 10'd20;   enemy_i.right = 10'd30;
        enemy_i.y_pos = 9'(py);   enemy_i.bottom = 9'(py + PADDLE_HEIGHT);
    endtask

    task automatic do_tick();
        exp_t e;
        rand_paddles();
        model_tick(e);
        exp_q.push_back(e);
        frame_tick_i = 1'b1;
        @(negedge clk_i);
        frame_tick_i = 1'b0;
        repeat ($urandom_range(3, 6)) @(negedge clk_i);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_x"},       ball_o.x_pos,   315);
        chk({tag, "_y"},       ball_o.y_pos,   235);
        chk({tag, "_right"},   ball_o.right,   325);
        chk({tag, "_bottom"},  ball_o.bottom,  245);
        chk({tag, "_speed_x"}, speed_x_o,      4);
        chk({tag, "_speed_y"}, speed_y_o,      1);
        chk({tag, "_dir_x"},   dir_x_o,        0);
        chk({tag, "_dir_y"},   dir_y_o,        1);
        chk({tag, "_serving"}, serving_o,      1);
        chk({tag, "_score_p"}, score_player_o, 0);
        chk({tag, "_score_e"}, score_enemy_o,  0);
    endtask

    // Monitor: after each accepted frame tick, pop the prediction and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            if (frame_tick_i && !rst_i) begin
                @(negedge clk_i);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got 0 entries required 1");
                end else begin
                    e = exp_q.pop_front();
                    chk("score_enemy_pulse",  score_enemy_o,  e.se);
                    chk("score_player_pulse", score_player_o, e.sp);
                    @(posedge clk_i);
                    @(negedge clk_i);
                    chk("score_enemy_after",  score_enemy_o,  0);
                    chk("score_player_after", score_player_o, 0);
                    chk("ball_x",      ball_o.x_pos,  e.x);
                    chk("ball_y",      ball_o.y_pos,  e.y);
                    chk("ball_right",  ball_o.right,  e.x + BALL_SIDE);
                    chk("ball_bottom", ball_o.bottom, e.y + BALL_SIDE);
                    chk("speed_x",     speed_x_o,     e.sx);
                    chk("speed_y",     speed_y_o,     e.sy);
                    chk("dir_x",       dir_x_o,       e.dx);
                    chk("dir_y",       dir_y_o,       e.dy);
                    chk("serving",     serving_o,     e.serving);
                end
            end
        end
    end

    // A frame tick must never land on the single collision-resolution cycle.
    always @(posedge clk_i) begin
        if (!rst_i && dut.r_state == CHECK) begin
            checks++;
            assert (!frame_tick_i) else begin
                errors++;
                $display("FAIL tick_in_check: got 1 required 0");
            end
        end
    end

    task automatic mid_reset();
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1 check_reset_outputs("async_reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        chk("queue_drained_at_reset", exp_q.size(), 0);
        did_reset = 1;
    endtask

    initial begin
        rst_i = 1'b1;
        frame_tick_i = 1'b0;
        model_reset();
        rand_paddles();
        repeat (2) @(negedge clk_i);
        check_reset_outputs("por");
        rst_i = 1'b0;
        @(negedge clk_i);

        for (int n = 1; n <= 61; n++) begin
            do_tick();
            if (n == 59) chk("serving_tick59", serving_o, 1);
            if (n == 60) begin
                chk("serving_tick60", serving_o, 0);
                chk("no_move_tick60", ball_o.x_pos, 315);
            end
            if (n == 61) begin
                chk("first_move_x", ball_o.x_pos, 311);
                chk("first_move_y", ball_o.y_pos, 236);
            end
        end

        for (int n = 0; n < 2500; n++) begin
            do_tick();
            if (!did_reset && n > 300 && m_serving == 0 && m_x >= 450) mid_reset();
        end
        if (!did_reset) mid_reset();

        repeat (4) @(negedge clk_i);
        chk("queue_empty_end", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
